// File: rtl/ahb_wait_reg_slave.sv
// AHB-Lite register slave with NREGS read/write words, a read-only status
// word, a fixed number of OKAY wait states and a two-cycle ERROR response.
`timescale 1ns/1ps

module ahb_wait_reg_slave #(
  parameter int NREGS       = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [11:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [32*NREGS-1:0]   REG_OUT
);

  localparam logic [9:0] LP_STATUS_IDX = 10'(NREGS);
  localparam logic [2:0] LP_WAIT_LOAD  = 3'(WAIT_STATES);
  localparam bit         LP_HAS_WAIT   = (WAIT_STATES > 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;

  // Captured address-phase information for the transfer in its data phase.
  logic [9:0]  r_widx;
  logic        r_write;
  logic [3:0]  r_lanes;

  logic [31:0] r_regs [NREGS];
  logic [15:0] r_wr_count;

  logic        w_accept;
  logic        w_take;
  logic        w_err;
  logic [3:0]  w_lanes;
  logic        w_commit;
  logic [31:0] w_rword;
  logic        w_unused;

  // Only the "active transfer" bit of HTRANS matters; SEQ and NONSEQ are alike here.
  assign w_unused = HTRANS[0];

  assign w_accept = HSEL & HREADY & HTRANS[1];

  // Decode byte lanes and error conditions of the address phase on the bus.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_lanes = 4'b0000;
    w_err   = 1'b0;
    case (HSIZE)
      3'd0: w_lanes = 4'b0001 << HADDR[1:0];
      3'd1: begin
        w_lanes = HADDR[1] ? 4'b1100 : 4'b0011;
        if (HADDR[0]) w_err = 1'b1;
      end
      3'd2: begin
        w_lanes = 4'b1111;
        if (HADDR[1:0] != 2'b00) w_err = 1'b1;
      end
      default: w_err = 1'b1;
    endcase
    if (HADDR[11:2] > LP_STATUS_IDX) w_err = 1'b1;
    if (HWRITE && (HADDR[11:2] == LP_STATUS_IDX)) w_err = 1'b1;
  end

  // Next-state and response outputs of the data-phase state machine.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_take      = 1'b0;
    HREADYOUT   = 1'b1;
    HRESP       = 1'b0;
    case (r_state)
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (r_cnt <= 3'd1) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      ST_ERR1: begin
        HREADYOUT   = 1'b0;
        HRESP       = 1'b1;
        w_state_nxt = ST_ERR2;
      end
      ST_IDLE, ST_DONE, ST_ERR2: begin
        // These are the only states where a new address phase can complete.
        HRESP = (r_state == ST_ERR2);
        if (w_accept) begin
          w_take = 1'b1;
          if (w_err) begin
            w_state_nxt = ST_ERR1;
          end else if (LP_HAS_WAIT) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = LP_WAIT_LOAD;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and wait counter registers.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order between blocks.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Capture address, direction and lanes when a transfer is accepted.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_widx  <= 10'd0;
      r_write <= 1'b0;
      r_lanes <= 4'b0000;
    end else if (w_take) begin
      r_widx  <= HADDR[11:2];
      r_write <= HWRITE;
      r_lanes <= w_lanes;
    end
  end

  // Errored writes never reach DONE, so they can never commit.
  assign w_commit = (r_state == ST_DONE) && r_write;

  // Commit write data lane by lane at the end of DONE and count the write.
  // NOTE: the register array is reset because its contents are visible on
  // REG_OUT and must read as zero straight out of reset.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      for (int n = 0; n < NREGS; n++) r_regs[n] <= 32'd0;
      r_wr_count <= 16'd0;
    end else if (w_commit) begin
      r_wr_count <= r_wr_count + 16'd1;
      for (int n = 0; n < NREGS; n++) begin
        if (r_widx == 10'(n)) begin
          for (int b = 0; b < 4; b++) begin
            if (r_lanes[b]) r_regs[n][8*b +: 8] <= HWDATA[8*b +: 8];
          end
        end
      end
    end
  end

  // Select the addressed word; any index that is not a register is the status word.
  always_comb begin
    w_rword = {16'hA5C3, r_wr_count};
    for (int n = 0; n < NREGS; n++) begin
      if (r_widx == 10'(n)) w_rword = r_regs[n];
    end
  end

  assign HRDATA = ((r_state == ST_DONE) && !r_write) ? w_rword : 32'd0;

  for (genvar g = 0; g < NREGS; g++) begin : g_reg_out
    assign REG_OUT[32*g +: 32] = r_regs[g];
  end

endmodule

// File: doc/ahb_wait_reg_slave.md
# ahb_wait_reg_slave

AHB-Lite slave register block with a parameterised number of wait states and a two-cycle ERROR response. It is the responder at the slave end of the bus. Its HREADYOUT, HRESP and HRDATA connect to one port of the slave multiplexer, and its HSEL comes from the address decoder. It provides NREGS read/write 32-bit registers plus one read-only status word, and is used to exercise stalled and errored data phases in the system.

## Interface
- NREGS, 8: number of R/W registers (1–8), at offsets 0x00..4*(NREGS-1)
- WAIT_STATES, 2: data-phase wait cycles for OKAY transfers (0–7)
- HCLK  in  1  clock
- HRESETn  in  1  reset, synchronous, active-low; sampled on the rising edge of HCLK
- HSEL  in  1  slave select from the decoder
- HADDR  in  12  byte address within the slave window
- HTRANS  in  2  transfer type; bit 1 set means NONSEQ or SEQ
- HWRITE  in  1  1 = write
- HSIZE  in  3  0 = byte, 1 = halfword, 2 = word
- HWDATA  in  32  write data, valid during the data phase
- HREADY  in  1  bus ready, from the mux HREADYOUT
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- HRDATA  out  32  read data
- REG_OUT  out  32*NREGS  flattened register contents; register n is at bits [32n+31:32n]

## Operation
- Accept condition: HSEL & HREADY & HTRANS[1] on a rising edge. The block captures address, write, size and byte-lane information.
- IDLE/BUSY transfers and unselected cycles get a zero-wait OKAY response.
- A captured transfer is an error if any of the following holds:
  - HSIZE > 2;
  - halfword access with HADDR[0] = 1;
  - word access with HADDR[1:0] != 0;
  - word offset HADDR[11:2] > NREGS, i.e. unmapped;
  - a write to the status offset, 4*NREGS.
- Status word, read-only at offset 4*NREGS: {16'hA5C3, wr_count[15:0]}.
  - wr_count increments by 1 on every committed write.
  - It wraps from 0xFFFF to 0x0000.
- Byte lanes are little-endian:
  - byte: lane HADDR[1:0];
  - halfword: lanes {HADDR[1],0} and {HADDR[1],1};
  - word: all four lanes.
  - Unselected lanes of the register are unchanged.
- Reads always return the full 32-bit word. Lane selection is the master's job.
- State machine:
  - IDLE: HREADYOUT=1, HRESP=0.
  - On accept of a valid transfer: go to WAIT with cnt=WAIT_STATES if WAIT_STATES>0; otherwise go to DONE.
  - On accept of an error transfer: go to ERR1.
  - WAIT: HREADYOUT=0, cnt decrements each cycle, move to DONE when cnt reaches 1.
  - DONE: final data-phase cycle. HREADYOUT=1, HRESP=0. The write is committed from HWDATA at the end of this cycle. A new accept in this cycle starts the next transfer; otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1; always go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. An accept in this cycle is handled as in DONE; otherwise go to IDLE.
- Errored writes never modify registers or wr_count.
- HRDATA carries the selected word only in DONE of a read. It is 0 in all other cycles, including ERR1 and ERR2.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, all registers 0, wr_count=0, state IDLE.
- Reset mid-transfer: reset is synchronous, so on the next edge the outputs take their reset values, a pending write is dropped, and the FSM returns to IDLE.
- OKAY transfers: the data phase lasts WAIT_STATES+1 cycles, with HREADYOUT low for the first WAIT_STATES cycles.
- ERROR transfers: always 2 cycles, regardless of WAIT_STATES.
- Register update is visible on REG_OUT in the cycle after DONE.
- Back-to-back pipelining:
  - The address phase of transfer N+1 overlaps the DONE or ERR2 cycle of transfer N.
  - A read at the same address as the preceding write returns the new value, because the write commits at the DONE edge before the read's DONE.
- The block samples no address-phase inputs while HREADY=0.

## Test plan
- Reset: hold HRESETn=0 for 2 cycles, then release -> HREADYOUT=1, HRESP=0, HRDATA=0, REG_OUT=0, status read = 0xA5C30000.
- Word write then read, WAIT_STATES=2: write 0xDEADBEEF to 0x04, then read 0x04 -> each data phase has 2 HREADYOUT-low cycles; read returns 0xDEADBEEF; status reads 0xA5C30001.
- Byte/halfword lanes: write word 0x11223344 to 0x08, then byte 0xAA at 0x09, then halfword 0x5566 at 0x0A -> register 2 = 0x5566AA44.
- Errors: write to the status offset, read 0x30, and a word access at 0x02 -> each gives ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); registers and wr_count unchanged.
- Back-to-back with WAIT_STATES=0: NONSEQ writes to 0x00 and 0x04 on consecutive cycles, then read 0x00 -> zero-wait OKAY on every transfer; read returns the written value.
- Counter wrap and mid-transfer reset:
  - Perform 65536 writes -> status low half returns to 0x0000.
  - Assert HRESETn=0 during WAIT -> next edge gives HREADYOUT=1 and the pending write is not committed.
